// File: rtl/mrd_mem_pkt.sv
// Shared widths, top-FSM state encodings and sample type for the mixed-radix DFT memory.
package mrd_mem_pkt;

  localparam int unsigned wDATA = 18;
  localparam int unsigned wADDR = 11;

  localparam logic [2:0] FSM_SINK   = 3'd1;
  localparam logic [2:0] FSM_SOURCE = 3'd5;

  typedef struct packed {
    logic [wDATA-1:0] re;
    logic [wDATA-1:0] im;
  } cplx_t;

endpackage

// File: rtl/mrd_fsm_sink_p2.sv
// Sink-phase write controller: takes two complex samples per beat while the top FSM is in Sink,
// writes them to the two-bank RAM in natural order, checks frame length and pulses sink_end.
module mrd_fsm_sink_p2
  import mrd_mem_pkt::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             fsm,
  input  logic [11:0]            dftpts,
  input  logic                   in_valid,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [4*wDATA-1:0]     in_data,
  output logic                   in_ready,
  output logic [1:0]             wr_en,
  output logic [2*wADDR-1:0]     wr_addr,
  output logic [4*wDATA-1:0]     wr_data,
  output logic                   sink_end,
  output logic [2:0]             err_flags
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int unsigned ERR_SHORT = 0;
  localparam int unsigned ERR_LONG  = 1;
  localparam int unsigned ERR_ABORT = 2;

  logic [1:0]             state_q, state_d;
  logic [wADDR-1:0]       cnt_q, cnt_d;
  logic [wADDR-1:0]       nbeats_q, nbeats_d;
  logic [2:0]             err_q, err_d;
  logic                   in_ready_q, in_ready_d;
  logic [1:0]             wr_en_q, wr_en_d;
  logic [2*wADDR-1:0]     wr_addr_q, wr_addr_d;
  logic [4*wDATA-1:0]     wr_data_q, wr_data_d;
  logic                   sink_end_q, sink_end_d;
  logic                   done_seen_q, done_seen_d;

  logic                   in_sink;
  logic                   beat;
  logic                   take;
  logic [wADDR-1:0]       idx;
  logic [wADDR-1:0]       n_cur;
  logic                   last;

  assign in_sink = (fsm == FSM_SINK);
  assign beat    = in_valid & in_ready_q & in_sink;

  // A sop beat always restarts at address 0 against the freshly latched frame length.
  assign idx   = in_sop ? '0 : cnt_q;
  assign n_cur = in_sop ? dftpts[11:1] : nbeats_q;
  assign last  = (idx == n_cur - wADDR'(1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nbeats_d    = nbeats_q;
    err_d       = err_q;
    wr_en_d     = 2'b00;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = in_data;
    sink_end_d  = 1'b0;
    done_seen_d = (state_q == ST_DONE);
    take        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (beat && in_sop) begin
          err_d = '0;
          take  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!in_sink) begin
          err_d[ERR_ABORT] = 1'b1;
          state_d          = ST_IDLE;
        end else if (beat) begin
          take = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!in_sink) begin
          err_d[ERR_ABORT] = 1'b1;
          state_d          = ST_IDLE;
        end else if (beat && in_eop) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        sink_end_d = !done_seen_q;
        if (!in_sink) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Accepted beat: write both banks, then classify against the frame length.
    if (take) begin
      if (in_sop) nbeats_d = dftpts[11:1];
      wr_en_d   = 2'b11;
      wr_addr_d = {idx, idx};
      cnt_d     = idx + wADDR'(1);
      if (in_eop) begin
        state_d = ST_DONE;
        if (!last) err_d[ERR_SHORT] = 1'b1;
      end else if (last) begin
        err_d[ERR_LONG] = 1'b1;
        state_d         = ST_DRAIN;
      end else begin
        state_d = ST_RUN;
      end
    end

    in_ready_d = in_sink && (state_d != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      nbeats_q    <= '0;
      err_q       <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      sink_end_q  <= 1'b0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbeats_q    <= nbeats_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      sink_end_q  <= sink_end_d;
      done_seen_q <= done_seen_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign sink_end  = sink_end_q;
  assign err_flags = err_q;

endmodule

// File: tb/tb_mrd_fsm_sink_p2.sv
// Directed bench for the sink-phase write controller: frame table plus abort, restart and reset sequences.
module tb_mrd_fsm_sink_p2;
  import mrd_mem_pkt::*;

  localparam int unsigned DW   = 4 * wDATA;
  localparam int unsigned AW   = 2 * wADDR;
  localparam int unsigned LOGN = 8192;

  logic              clk;
  logic              rst_n;
  logic [2:0]        fsm;
  logic [11:0]       dftpts;
  logic              in_valid;
  logic              in_sop;
  logic              in_eop;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic [1:0]        wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              sink_end;
  logic [2:0]        err_flags;

  mrd_fsm_sink_p2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fsm       (fsm),
    .dftpts    (dftpts),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .sink_end  (sink_end),
    .err_flags (err_flags)
  );

  typedef struct {
    int       dft;
    int       nb;
    int       eop_at;
    bit       gap;
    int       exp_wr;
    logic [2:0] exp_err;
    bit       follow;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wr_n  = 0;
  int se_n  = 0;
  int last_wr_cyc = 0;
  int se_cyc = 0;

  logic [1:0]        log_en [LOGN];
  logic [wADDR-1:0]  log_a0 [LOGN];
  logic [wADDR-1:0]  log_a1 [LOGN];
  logic [DW-1:0]     log_d  [LOGN];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every RAM write and sink_end pulse for the checker to inspect.
  always @(negedge clk) begin
    if (wr_en != 2'b00 && wr_n < int'(LOGN)) begin
      log_en[wr_n] <= wr_en;
      log_a0[wr_n] <= wr_addr[wADDR-1:0];
      log_a1[wr_n] <= wr_addr[AW-1:wADDR];
      log_d[wr_n]  <= wr_data;
      wr_n         <= wr_n + 1;
      last_wr_cyc  <= cyc;
    end
    if (sink_end) begin
      se_n   <= se_n + 1;
      se_cyc <= cyc;
    end
  end

  function automatic logic [DW-1:0] mk(input int j);
    return {wDATA'(4*j+3), wDATA'(4*j+2), wDATA'(4*j+1), wDATA'(4*j)};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
    end
  endtask

  task automatic send_beat(input logic sop, input logic eop, input int j);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sop   = sop;
      in_eop   = eop;
      in_data  = mk(j);
      ok       = in_ready;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: in_ready=%0b expected 1 within 20 cycles", in_ready);
    end
  endtask

  task automatic check_write(input string nm, input int li, input int ea);
    check(nm, 128'({log_en[li], log_a0[li], log_a1[li], log_d[li]}),
          128'({2'b11, wADDR'(ea), wADDR'(ea), mk(ea)}));
  endtask

  task automatic leave_sink();
    @(negedge clk);
    fsm = 3'd0;
    idle(2);
    fsm = FSM_SINK;
  endtask

  task automatic run_frame(input vec_t v);
    int base, sb;
    base   = wr_n;
    sb     = se_n;
    dftpts = 12'(v.dft);
    for (int j = 0; j < v.nb; j++) begin
      send_beat(j == 0, j == v.eop_at, j);
      if (v.gap) idle(1);
    end
    idle(3);
    check("done_in_ready", 128'(in_ready), 128'(0));
    check("write_count", 128'(wr_n - base), 128'(v.exp_wr));
    for (int k = 0; k < v.exp_wr && base + k < wr_n; k++)
      check_write("write", base + k, k);
    check("err_flags", 128'(err_flags), 128'(v.exp_err));
    check("sink_end_count", 128'(se_n - sb), 128'(1));
    if (v.follow)
      check("sink_end_timing", 128'(se_cyc), 128'(last_wr_cyc + 1));
    leave_sink();
  endtask

  vec_t tbl [6];
  int   base, sb;
  int   exp_a [10];

  initial begin
    tbl[0] = '{dft: 12,   nb: 6,    eop_at: 5,    gap: 1'b0, exp_wr: 6,    exp_err: 3'b000, follow: 1'b1};
    tbl[1] = '{dft: 12,   nb: 6,    eop_at: 5,    gap: 1'b1, exp_wr: 6,    exp_err: 3'b000, follow: 1'b1};
    tbl[2] = '{dft: 12,   nb: 4,    eop_at: 3,    gap: 1'b0, exp_wr: 4,    exp_err: 3'b001, follow: 1'b1};
    tbl[3] = '{dft: 12,   nb: 9,    eop_at: 8,    gap: 1'b0, exp_wr: 6,    exp_err: 3'b010, follow: 1'b0};
    tbl[4] = '{dft: 20,   nb: 10,   eop_at: 9,    gap: 1'b1, exp_wr: 10,   exp_err: 3'b000, follow: 1'b1};
    tbl[5] = '{dft: 4094, nb: 2047, eop_at: 2046, gap: 1'b0, exp_wr: 2047, exp_err: 3'b000, follow: 1'b1};
    exp_a  = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5};

    rst_n = 1'b0; fsm = 3'd0; dftpts = 12'd12;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check("rst_wr_en",    128'(wr_en),     128'(0));
    check("rst_wr_addr",  128'(wr_addr),   128'(0));
    check("rst_wr_data",  128'(wr_data),   128'(0));
    check("rst_sink_end", 128'(sink_end),  128'(0));
    check("rst_err",      128'(err_flags), 128'(0));
    check("rst_in_ready", 128'(in_ready),  128'(0));
    rst_n = 1'b1;
    fsm   = FSM_SINK;

    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    // fsm leaves Sink mid-frame: abort flag, no sink_end; next sop clears flags.
    base = wr_n; sb = se_n; dftpts = 12'd12;
    for (int j = 0; j < 3; j++) send_beat(j == 0, 1'b0, j);
    @(negedge clk);
    fsm = 3'd0; in_valid = 1'b0; in_sop = 1'b0;
    idle(2);
    check("abort_err",      128'(err_flags),   128'(3'b100));
    check("abort_writes",   128'(wr_n - base), 128'(3));
    check("abort_no_sink",  128'(se_n - sb),   128'(0));
    check("abort_in_ready", 128'(in_ready),    128'(0));
    fsm = FSM_SINK;
    run_frame(tbl[0]);

    // Pre-sop beats dropped, then a second sop restarts the frame at address 0.
    base = wr_n; sb = se_n; dftpts = 12'd12;
    send_beat(1'b0, 1'b0, 40);
    send_beat(1'b0, 1'b0, 41);
    for (int j = 0; j < 4; j++) send_beat(j == 0, 1'b0, j);
    for (int j = 0; j < 6; j++) send_beat(j == 0, j == 5, j);
    idle(3);
    check("restart_writes", 128'(wr_n - base), 128'(10));
    for (int k = 0; k < 10 && base + k < wr_n; k++)
      check_write("restart_write", base + k, exp_a[k]);
    check("restart_err",  128'(err_flags), 128'(0));
    check("restart_sink", 128'(se_n - sb), 128'(1));
    leave_sink();

    // Reset mid-frame: outputs cleared on the next edge and the frame never completes.
    base = wr_n; sb = se_n;
    for (int j = 0; j < 3; j++) send_beat(j == 0, 1'b0, j);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0;
    @(negedge clk);
    check("midrst_wr_en",    128'(wr_en),     128'(0));
    check("midrst_wr_addr",  128'(wr_addr),   128'(0));
    check("midrst_wr_data",  128'(wr_data),   128'(0));
    check("midrst_err",      128'(err_flags), 128'(0));
    check("midrst_in_ready", 128'(in_ready),  128'(0));
    check("midrst_sink_end", 128'(sink_end),  128'(0));
    rst_n = 1'b1;
    idle(4);
    check("midrst_no_sink", 128'(se_n - sb),   128'(0));
    check("midrst_writes",  128'(wr_n - base), 128'(3));
    run_frame(tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
